// File: rtl/uart_framed.sv
// uart_framed: full-duplex UART with configurable frame format.
// TX side takes bytes through a valid/ready handshake; RX side deposits good
// frames into a small first-word-fall-through FIFO and pulses one-cycle flags
// for framing, parity and overrun errors.
module uart_framed #(
    parameter int CLK_DIV    = 2,
    parameter int OVERSAMPLE = 4,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = 4;
    localparam int STOP_W = 2;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    // Occupancy runs 0..FIFO_DEPTH, so one bit wider than the pointers.
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic              PAR_EN    = (PARITY_EN != 0);
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    tx_state_t             tx_state_q, tx_state_d;
    logic [DIV_W-1:0]      tx_div_q, tx_div_d;
    logic [TICK_W-1:0]     tx_tick_q, tx_tick_d;
    logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
    logic [STOP_W-1:0]     tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;
    logic                  tx_div_tick;
    logic                  tx_bit_end;

    // TX next-state: bit timing, shifting and the registered serial level.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_div_d    = tx_div_q;
        tx_tick_d   = tx_tick_q;
        tx_bit_d    = tx_bit_q;
        tx_stop_d   = tx_stop_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_d        = tx_q;
        tx_div_tick = (tx_div_q == DIV_LAST);
        tx_bit_end  = tx_div_tick && (tx_tick_q == TICK_LAST);

        // The divider free-runs inside a frame; a bit ends on the last tick.
        if (tx_state_q != TX_IDLE) begin
            if (tx_div_tick) begin
                tx_div_d  = '0;
                tx_tick_d = (tx_tick_q == TICK_LAST) ? '0 : tx_tick_q + 1'b1;
            end else begin
                tx_div_d  = tx_div_q + 1'b1;
            end
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_d       = 1'b0;
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ PAR_ODD;
                    tx_div_d   = '0;
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BIT_LAST) begin
                        tx_stop_d = '0;
                        if (PAR_EN) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                    tx_stop_d  = '0;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_stop_d = tx_stop_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // TX state register; reset abandons any frame and parks the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_div_q   <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx_busy  = (tx_state_q != TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    logic                  rx_meta_q, rx_sync_q;
    rx_state_t             rx_state_q, rx_state_d;
    logic [DIV_W-1:0]      rx_div_q, rx_div_d;
    logic [TICK_W-1:0]     rx_tick_q, rx_tick_d;
    logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
    logic [STOP_W-1:0]     rx_stop_q, rx_stop_d;
    logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
    logic                  rx_par_bad_q, rx_par_bad_d;
    logic                  rx_stop_bad_q, rx_stop_bad_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  rx_div_tick;
    logic                  rx_half;
    logic                  rx_sample;
    logic                  stop_bad_now;
    logic                  push_req;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // RX next-state: start validation, mid-bit sampling and error decisions.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_div_d      = rx_div_q;
        rx_tick_d     = rx_tick_q;
        rx_bit_d      = rx_bit_q;
        rx_stop_d     = rx_stop_q;
        rx_shift_d    = rx_shift_q;
        rx_par_bad_d  = rx_par_bad_q;
        rx_stop_bad_d = rx_stop_bad_q;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        push_req      = 1'b0;
        stop_bad_now  = rx_stop_bad_q | ~rx_sync_q;
        rx_div_tick   = (rx_div_q == DIV_LAST);
        rx_half       = rx_div_tick && (rx_tick_q == TICK_HALF);
        rx_sample     = rx_div_tick && (rx_tick_q == TICK_LAST);

        if ((rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH)) begin
            if (rx_div_tick) begin
                rx_div_d  = '0;
                rx_tick_d = (rx_tick_q == TICK_LAST) ? '0 : rx_tick_q + 1'b1;
            end else begin
                rx_div_d  = rx_div_q + 1'b1;
            end
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d    = RX_START;
                    rx_div_d      = '0;
                    rx_tick_d     = '0;
                    rx_bit_d      = '0;
                    rx_par_bad_d  = 1'b0;
                    rx_stop_bad_d = 1'b0;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real start bit. Restarting
                // the divider here puts every later sample mid-bit.
                if (rx_half) begin
                    rx_div_d  = '0;
                    rx_tick_d = '0;
                    rx_bit_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_stop_d  = '0;
                        rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_par_bad_d = ((^rx_shift_q) ^ rx_sync_q) != PAR_ODD;
                    rx_stop_d    = '0;
                    rx_state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                // All verdicts are issued together on the last stop sample.
                if (rx_sample) begin
                    if (rx_stop_q == STOP_LAST) begin
                        frame_err_d  = stop_bad_now;
                        parity_err_d = rx_par_bad_q;
                        push_req     = ~stop_bad_now & ~rx_par_bad_q;
                        rx_state_d   = stop_bad_now ? RX_WAIT_HIGH : RX_IDLE;
                    end else begin
                        rx_stop_bad_d = stop_bad_now;
                        rx_stop_d     = rx_stop_q + 1'b1;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX state register and registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= RX_IDLE;
            rx_div_q      <= '0;
            rx_tick_q     <= '0;
            rx_bit_q      <= '0;
            rx_stop_q     <= '0;
            rx_shift_q    <= '0;
            rx_par_bad_q  <= 1'b0;
            rx_stop_bad_q <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_div_q      <= rx_div_d;
            rx_tick_q     <= rx_tick_d;
            rx_bit_q      <= rx_bit_d;
            rx_stop_q     <= rx_stop_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_bad_q  <= rx_par_bad_d;
            rx_stop_bad_q <= rx_stop_bad_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign rx_busy    = (rx_state_q != RX_IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

    // ------------------------------------------------------------------
    // RX FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;

    // FIFO next-state: a pop frees the slot, so push into a full FIFO is
    // accepted when a pop happens in the same cycle.
    always_comb begin
        fifo_full = (count_q == FIFO_FULL);
        pop       = (count_q != '0) && rx_ready;
        push_ok   = push_req && (!fifo_full || pop);
        overrun_d = push_req && fifo_full && !pop;
        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= rx_shift_q;
        end
    end

    assign rx_data     = fifo_mem[rd_ptr_q];
    assign rx_valid    = (count_q != '0);
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_framed.sv
// tb_uart_framed: directed bench for uart_framed. One instance with default
// 8N1 framing (with optional tx->rx loopback) and one with odd parity.
module tb_uart_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-format instance
    logic       loopback;
    logic       rx_drv;
    logic       rx_a, tx_a;
    logic [7:0] tx_data_a;
    logic       tx_valid_a, tx_ready_a, tx_busy_a;
    logic [7:0] rx_data_a;
    logic       rx_valid_a, rx_ready_a, rx_busy_a;
    logic       fe_a, pe_a, ov_a;

    assign rx_a = loopback ? tx_a : rx_drv;

    uart_framed dut (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_busy(tx_busy_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_busy(rx_busy_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a)
    );

    // Odd-parity instance
    logic       rx_p, tx_p;
    logic [7:0] tx_data_p;
    logic       tx_valid_p, tx_ready_p, tx_busy_p;
    logic [7:0] rx_data_p;
    logic       rx_valid_p, rx_ready_p, rx_busy_p;
    logic       fe_p, pe_p, ov_p;

    uart_framed #(.PARITY_EN(1), .PARITY_ODD(1)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .tx(tx_p),
        .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p), .tx_busy(tx_busy_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p), .rx_busy(rx_busy_p),
        .frame_err(fe_p), .parity_err(pe_p), .overrun_err(ov_p)
    );

    int total = 0;
    int bad = 0;
    int fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0;
    int fe_cnt_p = 0, pe_cnt_p = 0, ov_cnt_p = 0, both_p = 0;

    // Error pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (fe_a) fe_cnt_a++;
        if (pe_a) pe_cnt_a++;
        if (ov_a) ov_cnt_a++;
        if (fe_p) fe_cnt_p++;
        if (pe_p) pe_cnt_p++;
        if (ov_p) ov_cnt_p++;
        if (fe_p && pe_p) both_p++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit to_p, input logic v);
        if (to_p) rx_p = v;
        else      rx_drv = v;
    endtask

    // Drive one frame, 8 clk per bit, starting at the current negedge.
    // The line is left at the stop level.
    task automatic send_frame(input bit to_p, input logic [7:0] d, input bit with_par,
                              input logic par, input logic stop);
        set_line(to_p, 1'b0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(to_p, d[i]);
            repeat (8) @(negedge clk);
        end
        if (with_par) begin
            set_line(to_p, par);
            repeat (8) @(negedge clk);
        end
        set_line(to_p, stop);
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_a;
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_byte;
        logic       e;
        logic [7:0] ov_bytes [5];
        int         snap;

        rst = 1'b1; loopback = 1'b0; rx_drv = 1'b1; rx_p = 1'b1;
        tx_data_a = 8'h00; tx_valid_a = 1'b0; rx_ready_a = 1'b0;
        tx_data_p = 8'h00; tx_valid_p = 1'b0; rx_ready_p = 1'b0;
        ov_bytes[0] = 8'h11; ov_bytes[1] = 8'h22; ov_bytes[2] = 8'h33;
        ov_bytes[3] = 8'h44; ov_bytes[4] = 8'h55;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_tx_ready", tx_ready_a, 1);
        chk("rst_tx_busy", tx_busy_a, 0);
        chk("rst_rx_valid", rx_valid_a, 0);
        chk("rst_rx_busy", rx_busy_a, 0);
        chk("rst_errs", {fe_a, pe_a, ov_a}, 0);
        chk("rst_p_valid", rx_valid_p, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // TX 0xA5: start 8 clk, bits 1,0,1,0,0,1,0,1, stop, ready after 80 clk
        exp_byte = 8'hA5;
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        for (int j = 0; j <= 80; j++) begin
            if (j < 8)       e = 1'b0;
            else if (j < 72) e = exp_byte[(j - 8) / 8];
            else             e = 1'b1;
            chk("tx_line", tx_a, e);
            chk("tx_ready", tx_ready_a, (j >= 80) ? 1 : 0);
            if (j < 80) @(negedge clk);
        end
        chk("tx_busy_done", tx_busy_a, 0);

        // Loopback 0x3C
        repeat (4) @(negedge clk);
        snap = fe_cnt_a + pe_cnt_a + ov_cnt_a;
        loopback = 1'b1;
        tx_data_a = 8'h3C; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        for (int i = 0; i < 200 && !rx_valid_a; i++) @(negedge clk);
        chk("lb_valid", rx_valid_a, 1);
        chk("lb_data", rx_data_a, 8'h3C);
        for (int i = 0; i < 100 && !tx_ready_a; i++) @(negedge clk);
        chk("lb_tx_ready", tx_ready_a, 1);
        loopback = 1'b0;
        chk("lb_no_err", fe_cnt_a + pe_cnt_a + ov_cnt_a - snap, 0);
        pop_a();
        chk("lb_pop", rx_valid_a, 0);
        // Pop request on an empty FIFO must be ignored
        pop_a();
        chk("empty_pop", rx_valid_a, 0);

        // Odd parity: 0x07 has three ones, so the correct parity bit is 0
        snap = fe_cnt_p;
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("par_bad_pulse", pe_cnt_p, 1);
        chk("par_bad_empty", rx_valid_p, 0);
        chk("par_bad_no_fe", fe_cnt_p - snap, 0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("par_ok_valid", rx_valid_p, 1);
        chk("par_ok_data", rx_data_p, 8'h07);
        chk("par_ok_no_pe", pe_cnt_p, 1);
        // 0x06 needs parity 1; send 0 and a low stop bit: both flags together
        send_frame(1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rx_p = 1'b1;
        repeat (6) @(negedge clk);
        chk("both_fe", fe_cnt_p, 1);
        chk("both_pe", pe_cnt_p, 2);
        chk("both_same_cycle", both_p, 1);
        chk("both_head_kept", rx_data_p, 8'h07);

        // Frame error: stop low, line held low 40 clk from stop start
        snap = fe_cnt_a;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (32) @(negedge clk);
        chk("fe_pulse", fe_cnt_a - snap, 1);
        chk("fe_no_push", rx_valid_a, 0);
        chk("fe_wait_busy", rx_busy_a, 1);
        rx_drv = 1'b1;
        repeat (5) @(negedge clk);
        chk("fe_idle", rx_busy_a, 0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fe_next_valid", rx_valid_a, 1);
        chk("fe_next_data", rx_data_a, 8'h81);
        chk("fe_next_no_fe", fe_cnt_a - snap, 1);
        pop_a();
        chk("fe_next_pop", rx_valid_a, 0);

        // Overrun: five frames into a depth-4 FIFO with no pops
        snap = ov_cnt_a;
        for (int k = 0; k < 5; k++) begin
            send_frame(1'b0, ov_bytes[k], 1'b0, 1'b0, 1'b1);
            repeat (2) @(negedge clk);
            chk("ov_count", ov_cnt_a - snap, (k == 4) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            chk("ov_valid", rx_valid_a, 1);
            chk("ov_order", rx_data_a, ov_bytes[k]);
            pop_a();
        end
        chk("ov_drained", rx_valid_a, 0);

        // Pop in the same cycle as the push into a full FIFO: no overrun
        snap = ov_cnt_a;
        for (int k = 0; k < 4; k++) begin
            send_frame(1'b0, 8'h61 + 8'(k), 1'b0, 1'b0, 1'b1);
            repeat (2) @(negedge clk);
        end
        fork
            send_frame(1'b0, 8'h65, 1'b0, 1'b0, 1'b1);
            begin
                repeat (78) @(negedge clk);
                rx_ready_a = 1'b1;
                @(negedge clk);
                rx_ready_a = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        chk("pp_no_overrun", ov_cnt_a - snap, 0);
        for (int k = 0; k < 4; k++) begin
            chk("pp_order", rx_data_a, 8'h62 + 8'(k));
            pop_a();
        end
        chk("pp_drained", rx_valid_a, 0);

        // 3-clk glitch: start rejected, no push, no error
        snap = fe_cnt_a + pe_cnt_a + ov_cnt_a;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        @(negedge clk);
        chk("gl_busy", rx_busy_a, 1);
        repeat (20) @(negedge clk);
        chk("gl_idle", rx_busy_a, 0);
        chk("gl_no_push", rx_valid_a, 0);
        chk("gl_no_err", fe_cnt_a + pe_cnt_a + ov_cnt_a - snap, 0);

        // Reset in the middle of a TX frame
        tx_data_a = 8'h00; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_tx_low", tx_a, 0);
        chk("mid_tx_not_ready", tx_ready_a, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", tx_a, 1);
        chk("rst_mid_ready", tx_ready_a, 1);
        chk("rst_mid_busy", tx_busy_a, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
